// File: rtl/ip_tile_fsm_funnel_sequencer.sv
// ----------------------------------------------------------------------------
// ip_tile_fsm_funnel_sequencer
//
// Purpose:
//   Drives the tile's bitwise shifter over its CSR handshake to build a 32-bit
//   funnel shift (A << n) | (B >> (32-n)), or a rotate-left of A by n. The
//   shifter runs two passes: pass 1 shifts A left by n, and pass 2 shifts B
//   (or A again for a rotate) right by 32-n. Each pass result is captured on
//   the shifter's done flag. The two partial results are ORed together and
//   presented to the host. If the shifter never completes a pass, a watchdog
//   ends the operation with an error.
//
// Ports:
//   clk          single clock
//   arst_n       asynchronous, active-low reset
//   csr_in       host command: [15] start, [8:4] amount n, [0] 1 = rotate
//   data_reg_a   operand A
//   data_reg_b   operand B (ignored for rotate)
//   data_reg_c   final result, held until the next DONE or ERR
//   csr_out      host status: [15] busy, [1] error, [0] done
//   csr_in_re    one-cycle pulse when a host command is accepted
//   csr_out_we   one-cycle pulse in the DONE and ERR states
//   shf_csr_in   shifter command: [15] start, [8:4] amount, [3] left,
//                [2] right, [1] select B, [0] select A
//   shf_data_a   shifter operand A (latched A)
//   shf_data_b   shifter operand B (latched B, or latched A for rotate)
//   shf_data_c   shifter result
//   shf_csr_out  shifter status, only [0] (done) is used
// ----------------------------------------------------------------------------
module ip_tile_fsm_funnel_sequencer #(
    parameter int REG_WIDTH     = 32,
    parameter int CSR_IN_WIDTH  = 16,
    parameter int CSR_OUT_WIDTH = 16,
    parameter int TIMEOUT       = 64
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [CSR_IN_WIDTH-1:0]  csr_in,
    input  logic [REG_WIDTH-1:0]     data_reg_a,
    input  logic [REG_WIDTH-1:0]     data_reg_b,
    output logic [REG_WIDTH-1:0]     data_reg_c,
    output logic [CSR_OUT_WIDTH-1:0] csr_out,
    output logic                     csr_in_re,
    output logic                     csr_out_we,
    output logic [CSR_IN_WIDTH-1:0]  shf_csr_in,
    output logic [REG_WIDTH-1:0]     shf_data_a,
    output logic [REG_WIDTH-1:0]     shf_data_b,
    input  logic [REG_WIDTH-1:0]     shf_data_c,
    input  logic [CSR_OUT_WIDTH-1:0] shf_csr_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE1,
        S_WAIT1,
        S_ISSUE2,
        S_WAIT2,
        S_DONE,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [REG_WIDTH-1:0]    a_r;
    logic [REG_WIDTH-1:0]    b_r;
    logic [4:0]              n_r;
    logic [REG_WIDTH-1:0]    part_r;
    logic [REG_WIDTH-1:0]    result_r;
    logic [CNT_W-1:0]        wdog_cnt;
    logic                    csr_in_re_r;
    logic                    csr_out_we_r;
    logic [CSR_IN_WIDTH-1:0] shf_cmd_r;
    logic [CSR_IN_WIDTH-1:0] shf_cmd_nxt;

    logic       host_start;
    logic [4:0] host_n;
    logic       host_rotate;
    logic       shf_done;
    logic       accept;
    logic       wdog_expired;
    logic [4:0] n_cur;
    logic [4:0] n_right;

    assign host_start  = csr_in[15];
    assign host_n      = csr_in[8:4];
    assign host_rotate = csr_in[0];
    assign shf_done    = shf_csr_out[0];

    // Command bits the design does not interpret; collected so lint sees them used.
    logic unused_bits;
    assign unused_bits = ^{csr_in[14:9], csr_in[3:1], shf_csr_out[CSR_OUT_WIDTH-1:1]};

    assign accept = (state == S_IDLE) && host_start;

    // The counter reaches TIMEOUT-1 on the edge where it currently holds
    // TIMEOUT-2. That edge leaves the WAIT state, so ISSUE plus the WAIT
    // cycles add up to exactly TIMEOUT cycles before ERR.
    assign wdog_expired = (wdog_cnt == CNT_W'(TIMEOUT - 2));

    // The command register is loaded on the accept edge, before n_r holds the
    // new amount, so the live host amount is used on that edge.
    assign n_cur   = accept ? host_n : n_r;
    assign n_right = 5'(5'd0 - n_cur);

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (host_start) begin
                    state_nxt = (host_n == 5'd0) ? S_DONE : S_ISSUE1;
                end
            end
            S_ISSUE1: state_nxt = S_WAIT1;
            S_WAIT1: begin
                if (shf_done) begin
                    state_nxt = S_ISSUE2;
                end else if (wdog_expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_ISSUE2: state_nxt = S_WAIT2;
            S_WAIT2: begin
                if (shf_done) begin
                    state_nxt = S_DONE;
                end else if (wdog_expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The shifter command is registered. It is computed from the state being
    // entered so that the start bit is high during the ISSUE cycle itself.
    always_comb begin
        shf_cmd_nxt = '0;
        case (state_nxt)
            S_ISSUE1, S_WAIT1: begin
                shf_cmd_nxt[15]  = (state_nxt == S_ISSUE1);
                shf_cmd_nxt[8:4] = n_cur;
                shf_cmd_nxt[3]   = 1'b1;
                shf_cmd_nxt[0]   = 1'b1;
            end
            S_ISSUE2, S_WAIT2: begin
                shf_cmd_nxt[15]  = (state_nxt == S_ISSUE2);
                shf_cmd_nxt[8:4] = n_right;
                shf_cmd_nxt[2]   = 1'b1;
                shf_cmd_nxt[1]   = 1'b1;
            end
            default: shf_cmd_nxt = '0;
        endcase
    end

    // State register and single-cycle handshake pulses.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= S_IDLE;
            csr_in_re_r  <= 1'b0;
            csr_out_we_r <= 1'b0;
            shf_cmd_r    <= '0;
        end else begin
            state        <= state_nxt;
            csr_in_re_r  <= accept;
            csr_out_we_r <= (state_nxt == S_DONE) || (state_nxt == S_ERR);
            shf_cmd_r    <= shf_cmd_nxt;
        end
    end

    // Operands are latched only on acceptance, so a start that arrives while
    // the sequencer is busy cannot disturb a pass in flight. For a rotate,
    // A is latched into the B slot as well.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            a_r <= '0;
            b_r <= '0;
            n_r <= '0;
        end else if (accept) begin
            a_r <= data_reg_a;
            b_r <= host_rotate ? data_reg_a : data_reg_b;
            n_r <= host_n;
        end
    end

    // Watchdog counts cycles spent waiting on the shifter.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wdog_cnt <= '0;
        end else if ((state == S_ISSUE1) || (state == S_ISSUE2)) begin
            wdog_cnt <= '0;
        end else if ((state == S_WAIT1) || (state == S_WAIT2)) begin
            wdog_cnt <= wdog_cnt + CNT_W'(1);
        end
    end

    // Partial and final results. A shifter done outside a WAIT state does not
    // change anything here.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            part_r   <= '0;
            result_r <= '0;
        end else begin
            if ((state == S_WAIT1) && shf_done) begin
                part_r <= shf_data_c;
            end

            if (accept && (host_n == 5'd0)) begin
                result_r <= data_reg_a;
            end else if ((state == S_WAIT2) && shf_done) begin
                result_r <= part_r | shf_data_c;
            end else if (state_nxt == S_ERR) begin
                result_r <= '0;
            end
        end
    end

    // Host status is decoded directly from the state.
    always_comb begin
        csr_out     = '0;
        csr_out[15] = (state == S_ISSUE1) || (state == S_WAIT1) ||
                      (state == S_ISSUE2) || (state == S_WAIT2);
        csr_out[1]  = (state == S_ERR);
        csr_out[0]  = (state == S_DONE);
    end

    assign data_reg_c = result_r;
    assign csr_in_re  = csr_in_re_r;
    assign csr_out_we = csr_out_we_r;
    assign shf_csr_in = shf_cmd_r;
    assign shf_data_a = a_r;
    assign shf_data_b = b_r;

endmodule
